// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// One digit per slot: blanking at slot start, then drive; display data is snapshotted once per frame.
module sseg_scan_ctrl #(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZ_SUPPRESS  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   hex_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  output logic [3:0]              hex_out,
  output logic                    dp_out,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_start
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam bit               HAS_BLANK = (BLANK_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  logic [IDX_W-1:0]              idx, idx_nxt;
  logic                          load;
  logic                          slot_start;

  logic [N_DIGITS-1:0][3:0]      snap_hex, snap_hex_nxt;
  logic [N_DIGITS-1:0]           snap_dp, snap_dp_nxt;
  logic [N_DIGITS-1:0]           snap_den, snap_den_nxt;
  logic [N_DIGITS-1:0]           shown;
  logic                          tail_zero;

  logic [3:0]                    hex_nxt;
  logic                          dp_nxt;
  logic [N_DIGITS-1:0]           an_nxt;
  logic                          fs_nxt;

  // Scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next slot position; load marks frame start (from IDLE or on wrap to slot 0)
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    load       = 1'b0;
    slot_start = 1'b0;
    if (!en) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          load       = 1'b1;
          slot_start = 1'b1;
          cnt_nxt    = '0;
          idx_nxt    = '0;
        end
        default: begin
          if (cnt == CNT_LAST) begin
            slot_start = 1'b1;
            cnt_nxt    = '0;
            if (idx == IDX_LAST) begin
              idx_nxt = '0;
              load    = 1'b1;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      endcase
      state_nxt = (HAS_BLANK && (cnt_nxt < CNT_BLANK)) ? S_BLANK : S_DRIVE;
    end
  end

  // Snapshot seen by the upcoming cycle, so a fresh frame uses the new data at once
  always_comb begin
    snap_hex_nxt = snap_hex;
    snap_dp_nxt  = snap_dp;
    snap_den_nxt = snap_den;
    if (load) begin
      snap_hex_nxt = hex_in;
      snap_dp_nxt  = dp_in;
      snap_den_nxt = digit_en;
    end
  end

  // A digit is shown unless disabled or part of a run of blank leading zeros
  always_comb begin
    tail_zero = 1'b1;
    shown     = snap_den_nxt;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      tail_zero = tail_zero && (snap_hex_nxt[i] == 4'h0) && snap_dp_nxt[i];
      if (LZ_SUPPRESS && tail_zero) begin
        shown[i] = 1'b0;
      end
    end
  end

  // Registered output values derived from the upcoming slot position
  always_comb begin
    hex_nxt = hex_out;
    dp_nxt  = dp_out;
    an_nxt  = '1;
    fs_nxt  = load;
    if (slot_start) begin
      hex_nxt = snap_hex_nxt[idx_nxt];
      dp_nxt  = snap_dp_nxt[idx_nxt];
    end
    if ((state_nxt == S_DRIVE) && shown[idx_nxt]) begin
      an_nxt = ~(N_DIGITS'(1) << idx_nxt);
    end
  end

  // Snapshot and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_hex    <= '0;
      snap_dp     <= '0;
      snap_den    <= '0;
      hex_out     <= 4'h0;
      dp_out      <= 1'b1;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      snap_hex    <= snap_hex_nxt;
      snap_dp     <= snap_dp_nxt;
      snap_den    <= snap_den_nxt;
      hex_out     <= hex_nxt;
      dp_out      <= dp_nxt;
      an          <= an_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule
